seq_capture_fifo: RTL and testbench
===================================

// Module: seq_capture_fifo
// PURPOSE
// - Downstream consumer of the 16-bit Fibonacci sequence generator: samples its per-clock output while enabled,
//   buffers samples in a DEPTH-entry FIFO and presents them on a valid/ready read port for host/debug readout.
// - Flags 16-bit arithmetic wrap of the sequence (sample smaller than previous pushed sample) and counts drops.
// PARAMETERS
// - DATA_W   16  sample width; must match generator output width
// - DEPTH    16  FIFO entries; power of two, >= 2
// - DROP_W   8   width of saturating drop counter
// PORTS
// - clk        in   1              single clock, all state on posedge
// - rst        in   1              asynchronous, active-high reset
// - clr        in   1              synchronous flush: pointers, flags, counters
// - cap_en     in   1              push in_data this cycle (subject to space)
// - in_data    in   DATA_W         generator output sample
// - rd_ready   in   1              consumer accepts rd_data
// - rd_valid   out  1              FIFO non-empty
// - rd_data    out  DATA_W         head entry (first-word fall-through)
// - count      out  $clog2(DEPTH)+1  entries held
// - full       out  1              count == DEPTH
// - wrap_seen  out  1              sticky: a pushed sample < previous pushed sample
// - drop_cnt   out  DROP_W         saturating count of samples lost to full
// - seq_err    out  1              sticky checker error (0 if checker compiled out)
// BEHAVIOUR
// - Reset (rst=1, async): wr_ptr=rd_ptr=0, count=0, rd_valid=0, full=0, wrap_seen=0, drop_cnt=0, seq_err=0,
//   last-sample-valid=0; rd_data value don't-care while rd_valid=0. Memory contents not reset.
// - pop = rd_valid & rd_ready. push = cap_en & (!full | pop). Write latency: sample visible on rd_data the cycle
//   after push when FIFO was empty (1-cycle latency); zero-cycle read of head (FFT).
// - Simultaneous push+pop: count unchanged, both pointers advance; permitted when full (pop frees slot).
// - Drop: cap_en & full & !pop -> sample discarded, drop_cnt+1, holds at 2^DROP_W-1 (no wrap).
// - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty derived from count, not pointer compare.
// - wrap_seen: on push, if last-sample-valid and in_data < last pushed sample (unsigned) -> set; last pushed
//   sample updated on every push. Dropped samples do not update it.
// - clr: highest priority; same-cycle push/pop ignored; returns all state to reset values next cycle.
// - rst asserted mid-operation: immediate flush, rd_valid drops asynchronously; no partial pop reported.
// - Pop with rd_valid=0 is a no-op; no underflow state change.
// CONFIGURATION
// - Macro SEQ_CAP_CHECK_EN: when defined, an in-line sequence checker tracks the last two samples presented while
//   cap_en=1 (pushed or dropped); once two are held, each new presented sample must equal (p1+p2) mod 2^DATA_W,
//   else seq_err sets (sticky until rst/clr). cap_en=0 does not reset history.
// - Without SEQ_CAP_CHECK_EN: no checker logic, seq_err tied 0.
// STRUCTURE
// - Shared include seq_cap_defs.vh: DATA_W default, DEPTH default, DROP_W default, SEQ_START (=16'd1) constants.
// - One sub-module: seq_cap_ram (DEPTH x DATA_W, 1 write port, async read port, no reset); pointer/flag/checker
//   logic stays in seq_capture_fifo.
// TESTING
// - Fill: generator out 1,1,2,3,5.. with cap_en=1, rd_ready=0 for 16 cycles -> full=1, count=16; 17th cycle drop_cnt=1.
// - Drain: then rd_ready=1, cap_en=0 -> rd_data reads 1,1,2,3,...,987 in order, rd_valid falls after 16 pops.
// - Wrap: capture 25 consecutive terms with reading -> push of 9489 after 46368 sets wrap_seen; 46368 alone does not.
// - Full push+pop: full FIFO, cap_en=1 & rd_ready=1 -> count stays 16, drop_cnt unchanged, order preserved.
// - Saturation/clr: 300 drops at DROP_W=8 -> drop_cnt=255; clr=1 one cycle -> count=0, drop_cnt=0, wrap_seen=0.
// - Checker (SEQ_CAP_CHECK_EN): inject 1,1,2,4 -> seq_err=1 on cycle after 4; undefined macro -> seq_err stays 0.

Source files
------------

// File: rtl/seq_capture_fifo_pkg.sv
// Shared types, default parameters and helpers for seq_capture_fifo.
package seq_capture_fifo_pkg;

`include "seq_cap_defs.vh"

    localparam int SEQ_DATA_W = `SEQ_CAP_DATA_W;
    localparam int SEQ_DEPTH  = `SEQ_CAP_DEPTH;
    localparam int SEQ_DROP_W = `SEQ_CAP_DROP_W;

    // How many presented samples the sequence checker currently holds.
    typedef enum logic [1:0] {
        HIST_NONE = 2'd0,
        HIST_ONE  = 2'd1,
        HIST_TWO  = 2'd2
    } hist_state_e;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/seq_cap_defs.vh
// Shared default constants for the Fibonacci sample capture FIFO.
// Guarded so that several files may include it in one compilation.
`ifndef SEQ_CAP_DEFS_VH
`define SEQ_CAP_DEFS_VH

// Sample width; must match the generator output width.
`define SEQ_CAP_DATA_W 16
// FIFO depth in entries; power of two, at least 2.
`define SEQ_CAP_DEPTH  16
// Width of the saturating drop counter.
`define SEQ_CAP_DROP_W 8
// First term emitted by the upstream generator.
`define SEQ_CAP_START  16'd1

`endif

// File: rtl/seq_cap_ram.sv
// Sample storage: DEPTH x DATA_W, one synchronous write port and one
// combinational read port so the FIFO head is available without a read cycle.
// Contents are intentionally not reset.
module seq_cap_ram
    import seq_capture_fifo_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W,
    parameter int DEPTH  = SEQ_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write the accepted sample into its slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/seq_capture_fifo.sv
// seq_capture_fifo: captures Fibonacci generator samples into a FIFO with a
// first-word fall-through valid/ready read port, flags 16-bit wrap of the
// sequence and counts samples dropped while full.
// Optional feature: define SEQ_CAP_CHECK_EN to build the in-line sequence
// checker driving seq_err; otherwise seq_err is tied low.
module seq_capture_fifo
    import seq_capture_fifo_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W,
    parameter int DEPTH  = SEQ_DEPTH,
    parameter int DROP_W = SEQ_DROP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     cap_en,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     wrap_seen,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     seq_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              wrap_reg, wrap_next;
    logic [DATA_W-1:0] last_reg, last_next;
    logic              last_valid_reg, last_valid_next;
    logic [DROP_W-1:0] drop_reg, drop_next;

    logic is_full;
    logic is_empty;
    logic pop;
    logic push;
    logic drop;
    logic wr_en;

    // Full/empty come from the occupancy count; pointers alone are ambiguous.
    assign is_full  = (count_reg == CNT_W'(DEPTH));
    assign is_empty = (count_reg == '0);

    // A pop frees a slot in the same cycle, so a full FIFO may still accept.
    assign pop   = ~is_empty & rd_ready;
    assign push  = cap_en & (~is_full | pop);
    assign drop  = cap_en & is_full & ~pop;
    assign wr_en = push & ~clr;

    seq_cap_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_reg),
        .wdata (in_data),
        .raddr (rd_ptr_reg),
        .rdata (rd_data)
    );

    // Next-state for pointers, occupancy, wrap flag and drop counter; clr wins.
    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        wrap_next       = wrap_reg;
        last_next       = last_reg;
        last_valid_next = last_valid_reg;
        drop_next       = drop_reg;
        if (clr) begin
            wr_ptr_next     = '0;
            rd_ptr_next     = '0;
            count_next      = '0;
            wrap_next       = 1'b0;
            last_next       = '0;
            last_valid_next = 1'b0;
            drop_next       = '0;
        end else begin
            if (push) begin
                wr_ptr_next     = wr_ptr_reg + PTR_W'(1);
                last_next       = in_data;
                last_valid_next = 1'b1;
                if (last_valid_reg && (in_data < last_reg)) begin
                    wrap_next = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CNT_W'(1);
            end
            if (drop && (drop_reg != {DROP_W{1'b1}})) begin
                drop_next = drop_reg + DROP_W'(1);
            end
        end
    end

    // Capture state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            wrap_reg       <= 1'b0;
            last_reg       <= '0;
            last_valid_reg <= 1'b0;
            drop_reg       <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            wrap_reg       <= wrap_next;
            last_reg       <= last_next;
            last_valid_reg <= last_valid_next;
            drop_reg       <= drop_next;
        end
    end

`ifdef SEQ_CAP_CHECK_EN
    // p1 is the most recent presented sample, p2 the one before it.
    hist_state_e       hist_reg, hist_next;
    logic [DATA_W-1:0] p1_reg, p1_next;
    logic [DATA_W-1:0] p2_reg, p2_next;
    logic              err_reg, err_next;

    // Checker history: every sample presented with cap_en counts, even drops.
    always_comb begin
        hist_next = hist_reg;
        p1_next   = p1_reg;
        p2_next   = p2_reg;
        err_next  = err_reg;
        if (clr) begin
            hist_next = HIST_NONE;
            p1_next   = '0;
            p2_next   = '0;
            err_next  = 1'b0;
        end else if (cap_en) begin
            if ((hist_reg == HIST_TWO) && (in_data != (p1_reg + p2_reg))) begin
                err_next = 1'b1;
            end
            p2_next = p1_reg;
            p1_next = in_data;
            case (hist_reg)
                HIST_NONE: hist_next = HIST_ONE;
                HIST_ONE:  hist_next = HIST_TWO;
                default:   hist_next = HIST_TWO;
            endcase
        end
    end

    // Checker state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_reg <= HIST_NONE;
            p1_reg   <= '0;
            p2_reg   <= '0;
            err_reg  <= 1'b0;
        end else begin
            hist_reg <= hist_next;
            p1_reg   <= p1_next;
            p2_reg   <= p2_next;
            err_reg  <= err_next;
        end
    end

    assign seq_err = err_reg;
`else
    assign seq_err = 1'b0;
`endif

    assign rd_valid  = ~is_empty;
    assign count     = count_reg;
    assign full      = is_full;
    assign wrap_seen = wrap_reg;
    assign drop_cnt  = drop_reg;

endmodule

// File: tb/tb_seq_capture_fifo.sv
// Scoreboard bench for seq_capture_fifo: directed Fibonacci scenarios followed
// by randomized traffic, checked against a queue-based reference model.
module tb_seq_capture_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              cap_en;
    logic [DATA_W-1:0] in_data;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [4:0]        count;
    logic              full;
    logic              wrap_seen;
    logic [DROP_W-1:0] drop_cnt;
    logic              seq_err;

    seq_capture_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .cap_en    (cap_en),
        .in_data   (in_data),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .count     (count),
        .full      (full),
        .wrap_seen (wrap_seen),
        .drop_cnt  (drop_cnt),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] sb[$];      // expected FIFO contents, head first
    logic [DATA_W-1:0] hist[$];    // last presented samples (checker)
    int                model_cnt;
    bit                exp_wrap;
    int                exp_drop;
    bit                exp_err;
    bit                have_last;
    logic [DATA_W-1:0] last_s;
    bit                mon_en = 1'b0;

    // Fibonacci generator state
    logic [DATA_W-1:0] fa, fb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fib_restart();
        fa = 16'd1;
        fb = 16'd1;
    endtask

    task automatic next_fib(output logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] s;
        v  = fa;
        s  = fa + fb;
        fa = fb;
        fb = s;
    endtask

    task automatic clear_model();
        sb.delete();
        hist.delete();
        model_cnt = 0;
        exp_wrap  = 1'b0;
        exp_drop  = 0;
        exp_err   = 1'b0;
        have_last = 1'b0;
        last_s    = '0;
    endtask

    // One clock of stimulus; the model is updated just after the active edge.
    task automatic cycle(input logic c, input logic [DATA_W-1:0] d, input logic r, input logic cl);
        bit pop_m, push_m, drop_m;
        @(negedge clk);
        cap_en   = c;
        in_data  = d;
        rd_ready = r;
        clr      = cl;
        pop_m  = (model_cnt > 0) && r;
        push_m = c && ((model_cnt < DEPTH) || pop_m);
        drop_m = c && (model_cnt == DEPTH) && !pop_m;
        @(posedge clk);
        #1;
        if (cl) begin
            clear_model();
        end else begin
            if (push_m) begin
                sb.push_back(d);
                if (have_last && (d < last_s)) exp_wrap = 1'b1;
                last_s    = d;
                have_last = 1'b1;
            end
            model_cnt = model_cnt + int'(push_m) - int'(pop_m);
            if (drop_m && exp_drop < DROP_MAX) exp_drop++;
            if (c) begin
`ifdef SEQ_CAP_CHECK_EN
                if (hist.size() == 2) begin
                    logic [DATA_W-1:0] want;
                    want = hist[0] + hist[1];
                    if (d != want) exp_err = 1'b1;
                end
`endif
                hist.push_back(d);
                if (hist.size() > 2) void'(hist.pop_front());
            end
        end
    endtask

    // Monitor: compares status every cycle, pops the scoreboard on each read.
    initial begin
        logic [DATA_W-1:0] exp_d;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && !rst) begin
                chk("rd_valid", {31'd0, rd_valid}, {31'd0, sb.size() != 0});
                chk("count", {27'd0, count}, sb.size());
                chk("full", {31'd0, full}, {31'd0, sb.size() == DEPTH});
                chk("wrap_seen", {31'd0, wrap_seen}, {31'd0, exp_wrap});
                chk("drop_cnt", {24'd0, drop_cnt}, exp_drop);
                chk("seq_err", {31'd0, seq_err}, {31'd0, exp_err});
                if (rd_valid && rd_ready && !clr && sb.size() > 0) begin
                    exp_d = sb.pop_front();
                    chk("rd_data", {16'd0, rd_data}, {16'd0, exp_d});
                    $display("pop t=%0t data=%0d exp=%0d", $time, rd_data, exp_d);
                end
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] v;
        int drop_before;

        rst = 1'b0; clr = 1'b0; cap_en = 1'b0; rd_ready = 1'b0; in_data = '0;
        clear_model();
        fib_restart();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_valid", {31'd0, rd_valid}, 0);
        chk("rst_count", {27'd0, count}, 0);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_wrap", {31'd0, wrap_seen}, 0);
        chk("rst_drop", {24'd0, drop_cnt}, 0);
        chk("rst_seqerr", {31'd0, seq_err}, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Fill 16 terms without reading, then one drop
        fib_restart();
        for (int i = 0; i < DEPTH; i++) begin
            next_fib(v);
            cycle(1'b1, v, 1'b0, 1'b0);
        end
        chk("fill_full", {31'd0, full}, 1);
        chk("fill_count", {27'd0, count}, 16);
        next_fib(v);
        cycle(1'b1, v, 1'b0, 1'b0);
        chk("fill_drop", {24'd0, drop_cnt}, 1);

        // Drain: scoreboard checks 1,1,2,...,987 order
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("drain_empty", {31'd0, rd_valid}, 0);

        // Asynchronous reset mid-operation
        cycle(1'b0, '0, 1'b0, 1'b1);
        fib_restart();
        for (int i = 0; i < 5; i++) begin
            next_fib(v);
            cycle(1'b1, v, 1'b0, 1'b0);
        end
        @(negedge clk);
        cap_en = 1'b0; rd_ready = 1'b0; clr = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, rd_valid}, 0);
        chk("async_rst_count", {27'd0, count}, 0);
        clear_model();
        @(negedge clk);
        #1 rst = 1'b0;

        // Wrap: 25 consecutive terms with reading enabled
        cycle(1'b0, '0, 1'b0, 1'b1);
        fib_restart();
        for (int i = 1; i <= 25; i++) begin
            next_fib(v);
            cycle(1'b1, v, 1'b1, 1'b0);
            if (i == 24) chk("wrap_after_46368", {31'd0, wrap_seen}, 0);
            if (i == 25) chk("wrap_after_9489", {31'd0, wrap_seen}, 1);
        end

        // Full FIFO with simultaneous push and pop
        cycle(1'b0, '0, 1'b0, 1'b1);
        fib_restart();
        for (int i = 0; i < DEPTH; i++) begin
            next_fib(v);
            cycle(1'b1, v, 1'b0, 1'b0);
        end
        drop_before = exp_drop;
        for (int i = 0; i < 10; i++) begin
            next_fib(v);
            cycle(1'b1, v, 1'b1, 1'b0);
        end
        chk("pushpop_count", {27'd0, count}, 16);
        chk("pushpop_drop", {24'd0, drop_cnt}, drop_before);

        // Saturation of the drop counter, then clr
        for (int i = 0; i < 300; i++) begin
            next_fib(v);
            cycle(1'b1, v, 1'b0, 1'b0);
        end
        chk("drop_sat", {24'd0, drop_cnt}, 255);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("clr_count", {27'd0, count}, 0);
        chk("clr_drop", {24'd0, drop_cnt}, 0);
        chk("clr_wrap", {31'd0, wrap_seen}, 0);

        // Checker injection 1,1,2,4
        cycle(1'b1, 16'd1, 1'b1, 1'b0);
        cycle(1'b1, 16'd1, 1'b1, 1'b0);
        cycle(1'b1, 16'd2, 1'b1, 1'b0);
        chk("seqerr_before_4", {31'd0, seq_err}, 0);
        cycle(1'b1, 16'd4, 1'b1, 1'b0);
`ifdef SEQ_CAP_CHECK_EN
        chk("seqerr_after_4", {31'd0, seq_err}, 1);
`else
        chk("seqerr_after_4", {31'd0, seq_err}, 0);
`endif
        cycle(1'b0, '0, 1'b0, 1'b1);
        fib_restart();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic c, r, cl;
            c  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) == 0);
            cl = ($urandom_range(0, 99) == 0);
            next_fib(v);
            if ($urandom_range(0, 19) == 0) v = DATA_W'($urandom);
            cycle(c, v, r, cl);
            if (cl) fib_restart();
        end

        @(negedge clk);
        #3;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
